// File: rtl/sync_fifo_reader.sv
// Read-side companion for the synchronous FIFO: pops words into a 2-entry skid buffer,
// drives a registered valid/ready stream, and supports flush. Optional stats: SYNC_FIFO_READER_STATS_EN.
module sync_fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic [CNT_WIDTH-1:0]  words_flushed
);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  valid_q, valid_d;
  logic                  clear_buf;
  logic                  push, pop;

  // FSM next state and read strobe; fifo_dout is only valid in the rd_en cycle
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    flush_busy = 1'b0;
    flush_done = 1'b0;
    clear_buf  = 1'b0;
    case (state_q)
      RUN: begin
        fifo_rd_en = !fifo_empty && !flush && (cnt_q != 2'd2 || m_ready);
        if (flush) begin
          state_d   = FLUSH;
          clear_buf = 1'b1;
        end
      end
      FLUSH: begin
        flush_busy = 1'b1;
        fifo_rd_en = !fifo_empty;
        if (fifo_empty) state_d = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
    if (reset) fifo_rd_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  assign push = fifo_rd_en && (state_q == RUN);
  assign pop  = valid_q && m_ready;

  // Skid buffer: head is presented downstream, tail holds the second word
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (clear_buf) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_d = fifo_dout;
          else               tail_d = fifo_dout;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_d = fifo_dout;
          end else begin
            head_d = tail_q;
            tail_d = fifo_dout;
          end
        end
        default: ;
      endcase
    end
    valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = head_q;

`ifdef SYNC_FIFO_READER_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] out_q, out_d;
  logic [CNT_WIDTH-1:0] fl_q, fl_d;

  // Saturating counters; a pop in the flush-request cycle still counts as delivered
  always_comb begin
    out_d = out_q;
    fl_d  = fl_q;
    if (pop && !(&out_q)) out_d = out_q + CNT_ONE;
    if (fifo_rd_en && (state_q == FLUSH) && !(&fl_q)) fl_d = fl_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      fl_q  <= '0;
    end else begin
      out_q <= out_d;
      fl_q  <= fl_d;
    end
  end

  assign words_out     = out_q;
  assign words_flushed = fl_q;
`else
  assign words_out     = '0;
  assign words_flushed = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Randomized scoreboard bench for sync_fifo_reader: queue-based FIFO and stream model,
// monitor checks stream data and control flags every cycle on the falling edge.
module tb_sync_fifo_reader;
`ifdef SYNC_FIFO_READER_STATS_EN
  localparam int CW = 4;
  localparam bit STATS = 1'b1;
`else
  localparam int CW = 16;
  localparam bit STATS = 1'b0;
`endif
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          flush;
  logic          flush_busy;
  logic          flush_done;
  logic [CW-1:0] words_out;
  logic [CW-1:0] words_flushed;

  sync_fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .flush(flush), .flush_busy(flush_busy), .flush_done(flush_done),
    .words_out(words_out), .words_flushed(words_flushed)
  );

  always #5 clk = ~clk;

  typedef enum {M_RUN, M_FLUSH, M_DONE} mode_t;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  mode_t         mode = M_RUN;
  int            n_out = 0;
  int            n_fl  = 0;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int sat(input int n);
    int mx;
    mx = (1 << CW) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic void upd_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? '0 : fifo_q[0];
  endfunction

  // Monitor: all comparisons happen here, mid-cycle, before consuming a delivered word
  always @(negedge clk) begin : monitor
    int   sz;
    logic exp_rd;
    sz = exp_q.size();
    exp_rd = !reset && !fifo_empty &&
             (mode == M_FLUSH || (mode == M_RUN && !flush && (sz < 2 || m_ready)));
    chk("rd_en", fifo_rd_en, exp_rd);
    chk("m_valid", m_valid, sz != 0);
    chk("flush_busy", flush_busy, mode == M_FLUSH);
    chk("flush_done", flush_done, mode == M_DONE);
    chk("words_out", words_out, STATS ? sat(n_out) : 0);
    chk("words_flushed", words_flushed, STATS ? sat(n_fl) : 0);
    if (m_valid) begin
      if (sz == 0) chk("data_unexpected", 1, 0);
      else         chk("m_data", m_data, exp_q[0]);
    end
    if (!reset && m_valid && m_ready && sz != 0) begin
      void'(exp_q.pop_front());
      n_out++;
    end
  end

  // Sample the current cycle, apply its effects to the model, then set next-cycle inputs
  task automatic tick(input int push_n, input bit rdy, input bit fl, input bit rst);
    logic s_rd, s_fl, s_rst, s_empty;
    @(negedge clk);
    s_rd = fifo_rd_en; s_fl = flush; s_rst = reset; s_empty = fifo_empty;
    @(posedge clk);
    #1;
    if (s_rd && fifo_q.size() != 0) begin
      if (mode == M_RUN) exp_q.push_back(fifo_q[0]);
      else if (mode == M_FLUSH) n_fl++;
      void'(fifo_q.pop_front());
    end
    if (s_rst) begin
      exp_q.delete();
      mode  = M_RUN;
      n_out = 0;
      n_fl  = 0;
    end else begin
      case (mode)
        M_RUN:   if (s_fl) begin exp_q.delete(); mode = M_FLUSH; end
        M_FLUSH: if (s_empty) mode = M_DONE;
        default: mode = M_RUN;
      endcase
    end
    for (int i = 0; i < push_n; i++) fifo_q.push_back(DW'($urandom));
    upd_fifo();
    m_ready = rdy;
    flush   = fl;
    reset   = rst;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; m_ready = 1'b1;
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    upd_fifo();
    // Reset with a non-empty FIFO: no reads may happen
    tick(0, 1, 0, 1);
    tick(0, 1, 0, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_m_valid", m_valid, 0);
    // Pass-through with m_ready held high
    repeat (6) tick(0, 1, 0, 0);
    // Backpressure then release
    tick(5, 0, 0, 0);
    repeat (6) tick(0, 0, 0, 0);
    repeat (8) tick(0, 1, 0, 0);
    // Empty guard with toggling ready
    for (int i = 0; i < 20; i++) tick(0, i[0], 0, 0);
    // Flush with full buffer and 4 words left in the FIFO
    tick(6, 0, 0, 0);
    repeat (4) tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 1, 0, 0);
    repeat (8) tick(0, 1, 0, 0);
    if (STATS) chk("flush_count", words_flushed, 4);
    // Reset during the second discard read
    tick(6, 0, 0, 0);
    repeat (4) tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 1, 0, 0);
    chk("midflush_rst_valid", m_valid, 0);
    chk("midflush_rst_data", m_data, 0);
    chk("midflush_rst_busy", flush_busy, 0);
    chk("midflush_rst_flushed", words_flushed, 0);
    repeat (10) tick(0, 1, 0, 0);
    // Randomized traffic, flushes and resets
    repeat (3000) tick(($urandom % 3 == 0) ? 1 : 0, ($urandom % 4) != 0,
                       ($urandom % 50) == 0, ($urandom % 500) == 0);
    repeat (20) tick(0, 1, 0, 0);
    // Flush of an already-empty FIFO: done pulses two cycles after the request
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    chk("empty_flush_done", flush_done, 1);
    repeat (3) tick(0, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
